// File: rtl/seq_signed_div.sv
// seq_signed_div: sequential restoring signed divider, one quotient bit per clock
// Ports: clk, rst_n (async, active-low); start/a[N]/b[M] request and operands;
//        busy/done handshake; q[N] quotient (toward zero), r[M] remainder (sign of a);
//        dz divide-by-zero, ovf quotient overflow (-2^(N-1) / -1).
// Build option: define DIV_EARLY_OUT_EN to finish in one step when |a| < |b|.
module seq_signed_div #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [M-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] q,
   output logic [M-1:0] r,
   output logic         dz,
   output logic         ovf
);
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  a_q, a_d, dvd_q, dvd_d, q_q, q_d;
   logic [M-1:0]  b_q, b_d, bm_q, bm_d, r_q, r_d;
   logic [M:0]    rem_q, rem_d, rem_sh;
   logic [M+1:0]  diff;
   logic          dz_q, dz_d, ovf_q, ovf_d, early;
   // dvd_q starts as |a| and shifts left; quotient bits enter at the LSB,
   // so after N steps it holds the unsigned quotient.
`ifdef DIV_EARLY_OUT_EN
   assign early = (cnt_q == '0) && (dvd_q < N'(bm_q));
`else
   assign early = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      dvd_d   = dvd_q;
      bm_d    = bm_q;
      rem_d   = rem_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      rem_sh  = {rem_q[M-1:0], dvd_q[N-1]};
      diff    = {1'b0, rem_sh} - {2'b00, bm_q};
      if (start && (state_q == IDLE || state_q == DONE)) begin
         a_d     = a;
         b_d     = b;
         dvd_d   = a[N-1] ? -a : a;
         bm_d    = b[M-1] ? -b : b;
         rem_d   = '0;
         cnt_d   = '0;
         dz_d    = 1'b0;
         ovf_d   = 1'b0;
         state_d = CALC;
      end else if (state_q == CALC) begin
         if (bm_q == '0) begin
            q_d     = '0;
            r_d     = '0;
            dz_d    = 1'b1;
            state_d = DONE;
         end else if (early) begin
            q_d     = '0;
            r_d     = a_q[M-1:0];
            state_d = DONE;
         end else begin
            rem_d   = diff[M+1] ? rem_sh : diff[M:0];
            dvd_d   = {dvd_q[N-2:0], ~diff[M+1]};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(N-1)) ? FIX : CALC;
         end
      end else if (state_q == FIX) begin
         // -2^(N-1) / -1 yields magnitude 2^(N-1), which already wraps to the required pattern
         q_d     = (a_q[N-1] ^ b_q[M-1]) ? -dvd_q : dvd_q;
         r_d     = a_q[N-1] ? -rem_q[M-1:0] : rem_q[M-1:0];
         ovf_d   = (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == {M{1'b1}});
         state_d = DONE;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         dvd_q   <= '0;
         bm_q    <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dvd_q   <= dvd_d;
         bm_q    <= bm_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy = (state_q == CALC) || (state_q == FIX);
   assign done = (state_q == DONE);
   assign q    = q_q;
   assign r    = r_q;
   assign dz   = dz_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_seq_signed_div.sv
// tb_seq_signed_div: directed self-checking bench for seq_signed_div (N=8, M=4)
module tb_seq_signed_div;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [7:0] a = '0, q;
   logic [3:0] b = '0, r;
   logic       busy, done, dz, ovf;
   int         checks = 0, errors = 0, n, bc;
   seq_signed_div #(.N(8), .M(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .q(q), .r(r), .dz(dz), .ovf(ovf)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Issues one operation; n = edges after the accept edge until done, bc = busy samples seen.
   task automatic run(input logic [7:0] ta, input logic [3:0] tb, input bit inj,
                      output int tn, output int tbc);
      @(negedge clk);
      a = ta; b = tb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tn = 99;
      tbc = int'(busy);
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         tbc += int'(busy);
         if (inj && i == 2) begin start = 1'b1; a = 8'd1; b = 4'd1; end
         else start = 1'b0;
         if (done) begin tn = i; break; end
      end
      start = 1'b0;
   endtask
   initial begin
      #12;
      check("rst_busy", busy, 0); check("rst_done", done, 0);
      check("rst_q", q, 0); check("rst_r", r, 0);
      check("rst_dz", dz, 0); check("rst_ovf", ovf, 0);
      @(negedge clk) rst_n = 1'b1;
      run(8'd100, 4'd7, 0, n, bc);
      check("p100_7_lat", n, 9); check("p100_7_busy", bc, 9);
      check("p100_7_q", q, 8'h0E); check("p100_7_r", r, 4'h2);
      check("p100_7_dz", dz, 0); check("p100_7_ovf", ovf, 0);
      run(8'h9C, 4'd7, 0, n, bc);
      check("m100_7_lat", n, 9);
      check("m100_7_q", q, 8'hF2); check("m100_7_r", r, 4'hE);
      run(8'd100, 4'h8, 0, n, bc);
      check("p100_m8_q", q, 8'hF4); check("p100_m8_r", r, 4'h4);
      run(8'h80, 4'hF, 0, n, bc);
      check("ovf_lat", n, 9); check("ovf_q", q, 8'h80);
      check("ovf_r", r, 4'h0); check("ovf_flag", ovf, 1);
      run(8'd6, 4'd3, 0, n, bc);
      check("p6_3_ovf", ovf, 0); check("p6_3_q", q, 8'h02); check("p6_3_r", r, 4'h0);
      run(8'd5, 4'd0, 0, n, bc);
      check("dz_lat", n, 1); check("dz_busy", bc, 1); check("dz_flag", dz, 1);
      check("dz_q", q, 0); check("dz_r", r, 0);
      run(8'd3, 4'd7, 0, n, bc);
      check("p3_7_lat", n, 9); check("p3_7_dz", dz, 0);
      check("p3_7_q", q, 0); check("p3_7_r", r, 4'h3);
      run(8'd100, 4'd7, 1, n, bc);
      check("ign_lat", n, 9); check("ign_q", q, 8'h0E); check("ign_r", r, 4'h2);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      @(negedge clk);
      a = 8'h9C; b = 4'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("abort_busy_pre", busy, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0); check("abort_done", done, 0);
      check("abort_q", q, 0); check("abort_r", r, 0);
      check("abort_dz", dz, 0); check("abort_ovf", ovf, 0);
      bc = 0;
      repeat (4) begin @(posedge clk); #1 bc += int'(done); end
      check("abort_no_done", bc, 0);
      @(negedge clk) rst_n = 1'b1;
      run(8'd100, 4'd7, 0, n, bc);
      check("restart_lat", n, 9); check("restart_q", q, 8'h0E); check("restart_r", r, 4'h2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
